// File: rtl/vuart_bus_arbiter.sv
// vuart_bus_arbiter: round-robin sharing of the virtual-UART register port between requesters
module vuart_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ-1:0]          i_req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]           o_rsp_rdata,
    output logic [ADDR_W-1:0]           o_urt_addr,
    output logic                        o_urt_write,
    output logic [DATA_W-1:0]           o_urt_writedata,
    output logic                        o_urt_read,
    input  logic [DATA_W-1:0]           i_urt_readdata,
    output logic                        o_busy,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [GW-1:0]     r_last, r_gid, w_win;
    logic              w_found, w_accept, r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [2:0]        r_cnt;

    assign o_urt_addr      = r_addr;
    assign o_urt_writedata = r_wdata;
    assign o_grant_id      = r_gid;
    assign o_busy          = r_state != S_IDLE;
    assign o_rsp_rdata     = (r_state == S_RESP && !r_wr) ? r_rdata : '0;

    // Pick the first valid requester searching upward from the one after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req_valid[(int'(r_last) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = GW'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    // Next state, UART strobes and requester handshakes.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        o_req_ready = '0;
        o_rsp_valid = '0;
        o_urt_write = 1'b0;
        o_urt_read  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !rst) begin
                    w_accept           = 1'b1;
                    o_req_ready[w_win] = 1'b1;
                    w_next             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_urt_write = r_wr;
                o_urt_read  = !r_wr;
                w_next      = r_wr ? S_RESP : S_WAIT;
            end
            S_WAIT: w_next = (r_cnt == '0) ? S_RESP : S_WAIT;
            S_RESP: begin
                o_rsp_valid[r_gid] = 1'b1;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Capture the granted payload, count read latency and latch read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= GW'(NUM_REQ - 1);
            r_gid   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_gid   <= w_win;
                r_wr    <= i_req_write[w_win];
                r_addr  <= i_req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                r_wdata <= i_req_wdata[int'(w_win)*DATA_W +: DATA_W];
            end
            if (r_state == S_ISSUE) r_cnt <= 3'(RD_LATENCY - 1);
            if (r_state == S_WAIT) begin
                if (r_cnt == '0) r_rdata <= i_urt_readdata;
                else             r_cnt   <= r_cnt - 3'd1;
            end
            if (r_state == S_RESP) r_last <= r_gid;
        end
    end
endmodule
